// File: rtl/reset_release_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : reset_release_sequencer
// Purpose  : Synchronizes a reset request and releases NUM_DOMAINS resets in
//            order, each gated on the previous domain's ready acknowledge.
// Revision : 1.0
// ============================================================================
module reset_release_sequencer #(
  parameter int SYNC_STAGES = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int NUM_DOMAINS = 4,
  parameter int ACK_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_in,
  input  logic [NUM_DOMAINS-1:0] ack_in,
  output logic [NUM_DOMAINS-1:0] rst_out,
  output logic                   done,
  output logic [NUM_DOMAINS-1:0] err
);

  localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [1:0] S_ASSERT = 2'd0;
  localparam logic [1:0] S_HOLD   = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RUN    = 2'd3;

  localparam logic [CNT_W-1:0]       C_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]       C_ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [IDX_W-1:0]       C_IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);
  localparam logic [NUM_DOMAINS-1:0] C_ONE       = NUM_DOMAINS'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [1:0]             r_state;
  logic [IDX_W-1:0]       r_idx;
  logic [CNT_W-1:0]       r_cnt;
  logic [NUM_DOMAINS-1:0] r_rst_out;
  logic                   r_done;
  logic [NUM_DOMAINS-1:0] r_err;

  logic                   w_req_s;
  logic [NUM_DOMAINS-1:0] w_idx_mask;
  logic                   w_ack_sel;

  assign w_req_s    = r_sync[SYNC_STAGES-1];
  assign w_idx_mask = C_ONE << r_idx;
  // Mask-based select keeps the index in range for any NUM_DOMAINS.
  assign w_ack_sel  = |(ack_in & w_idx_mask);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync    <= '1;
      r_state   <= S_ASSERT;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_rst_out <= '1;
      r_done    <= 1'b0;
      r_err     <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], req_in};
      // A returning request overrides any ack or timeout in the same cycle.
      if (r_state != S_ASSERT && w_req_s) begin
        r_state   <= S_ASSERT;
        r_idx     <= '0;
        r_cnt     <= '0;
        r_rst_out <= '1;
        r_done    <= 1'b0;
      end else begin
        case (r_state)
          S_ASSERT: begin
            r_rst_out <= '1;
            r_done    <= 1'b0;
            r_idx     <= '0;
            r_cnt     <= '0;
            if (!w_req_s) begin
              r_state <= S_HOLD;
            end
          end
          S_HOLD: begin
            if (r_cnt == C_HOLD_LAST) begin
              r_state   <= S_WAIT;
              r_idx     <= '0;
              r_cnt     <= '0;
              r_rst_out <= r_rst_out & ~C_ONE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_WAIT: begin
            if (w_ack_sel || (r_cnt == C_ACK_LAST)) begin
              if (!w_ack_sel) begin
                r_err <= r_err | w_idx_mask;
              end
              r_cnt <= '0;
              if (r_idx == C_IDX_LAST) begin
                r_state <= S_RUN;
                r_done  <= 1'b1;
              end else begin
                r_idx     <= r_idx + 1'b1;
                r_rst_out <= r_rst_out & ~(w_idx_mask << 1);
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_RUN: begin
            r_done    <= 1'b1;
            r_rst_out <= '0;
          end
          default: begin
            r_state   <= S_ASSERT;
            r_rst_out <= '1;
            r_done    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rst_out = r_rst_out;
  assign done    = r_done;
  assign err     = r_err;

endmodule
`default_nettype wire
